// File: rtl/regfile_scoreboard_if.sv
// Register-file / scoreboard bus: read ports, decode issue handshake and writeback.
// The master side is the pipeline (decode + writeback), the slave side is the register file.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            iss_valid;
    logic            iss_wen;
    logic [AW-1:0]   iss_rd;
    logic            iss_stall;
    logic            iss_accept;

    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    logic [AW:0]     pend_cnt;

    modport master (
        output rs1_addr, rs2_addr, iss_valid, iss_wen, iss_rd, wb_en, wb_rd, wb_data,
        input  rs1_data, rs2_data, iss_stall, iss_accept, pend_cnt
    );

    modport slave (
        input  rs1_addr, rs2_addr, iss_valid, iss_wen, iss_rd, wb_en, wb_rd, wb_data,
        output rs1_data, rs2_data, iss_stall, iss_accept, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass and a per-register write-pending
// scoreboard that stalls decode on RAW/WAW hazards against in-flight writes.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    logic [NREGS-1:0] eff_pend;
    logic             wb_we;
    logic             iss_set;
    logic             stall;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;

    assign wb_we = bus.wb_en && (bus.wb_rd != '0);

    // A register retiring this cycle no longer blocks issue, so the pending view is
    // masked by the writeback port before it feeds the stall logic.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
        if (gi == 0) begin : g_zero
            assign eff_pend[gi] = 1'b0;
            assign pend_d[gi]   = 1'b0;
        end else begin : g_reg
            assign eff_pend[gi] = pend_q[gi] & ~(bus.wb_en && (bus.wb_rd == AW'(gi)));
            // Set wins over clear when a new writer issues as the old one retires.
            assign pend_d[gi]   = (iss_set && (bus.iss_rd == AW'(gi)))
                                | (pend_q[gi] & ~(wb_we && (bus.wb_rd == AW'(gi))));
        end
    end

    assign stall = bus.iss_valid
                 & (eff_pend[bus.rs1_addr]
                  | eff_pend[bus.rs2_addr]
                  | (bus.iss_wen & eff_pend[bus.iss_rd]));

    assign iss_set = bus.iss_valid && !stall && bus.iss_wen && (bus.iss_rd != '0);

    // Counter tracks popcount of pend_q; only clears of bits actually set decrement it.
    assign cnt_d = cnt_q + (AW + 1)'(iss_set) - (AW + 1)'(wb_we & pend_q[bus.wb_rd]);

    always_comb begin
        rd1 = '0;
        if (bus.rs1_addr != '0) begin
            rd1 = (bus.wb_en && (bus.wb_rd == bus.rs1_addr)) ? bus.wb_data : regs_q[bus.rs1_addr];
        end
    end

    always_comb begin
        rd2 = '0;
        if (bus.rs2_addr != '0) begin
            rd2 = (bus.wb_en && (bus.wb_rd == bus.rs2_addr)) ? bus.wb_data : regs_q[bus.rs2_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.rs1_data   = rd1;
    assign bus.rs2_data   = rd2;
    assign bus.iss_stall  = stall;
    assign bus.iss_accept = bus.iss_valid & ~stall;
    assign bus.pend_cnt   = cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, RAW/WAW stalls, counter fill
// and asynchronous reset mid-operation, with hand-computed expectations.
module tb_regfile_scoreboard;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.iss_valid = 1'b0;
        bus.iss_wen   = 1'b0;
        bus.iss_rd    = '0;
        bus.wb_en     = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.rs1_addr  = '0;
        bus.rs2_addr  = '0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle();
        rst_n = 1'b0;

        // Reset state: every index reads zero on both ports
        #2;
        for (int i = 0; i < NREGS; i++) begin
            bus.rs1_addr = 5'(i);
            bus.rs2_addr = 5'(NREGS - 1 - i);
            #1;
            chk($sformatf("rst_rd1_x%0d", i), bus.rs1_data, 32'h0);
            chk($sformatf("rst_rd2_x%0d", NREGS - 1 - i), bus.rs2_data, 32'h0);
        end
        chk("rst_pend_cnt", 32'(bus.pend_cnt), 32'd0);
        #20;
        rst_n = 1'b1;
        step();
        idle();
        bus.iss_valid = 1'b1;
        #1;
        chk("rst_stall", 32'(bus.iss_stall), 32'd0);
        chk("rst_accept", 32'(bus.iss_accept), 32'd1);

        // Writes to x0 are discarded, with no bypass either
        idle();
        bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEADBEEF;
        #1;
        chk("x0_bypass", bus.rs1_data, 32'h0);
        step();
        idle();
        #1;
        chk("x0_store", bus.rs1_data, 32'h0);
        chk("x0_pend_cnt", 32'(bus.pend_cnt), 32'd0);

        // Write and bypass
        bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h1234;
        bus.rs1_addr = 5'd5;
        #1;
        chk("wb_bypass_x5", bus.rs1_data, 32'h1234);
        chk("wb_bypass_rs2_x0", bus.rs2_data, 32'h0);
        step();
        bus.wb_en = 1'b0; bus.wb_data = '0;
        #1;
        chk("wb_store_x5", bus.rs1_data, 32'h1234);
        chk("wb_nonpend_cnt", 32'(bus.pend_cnt), 32'd0);

        // RAW stall on x7
        idle();
        bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd7;
        #1;
        chk("raw_issue_accept", 32'(bus.iss_accept), 32'd1);
        step();
        chk("raw_pend_cnt1", 32'(bus.pend_cnt), 32'd1);
        bus.iss_wen = 1'b0; bus.iss_rd = '0; bus.rs2_addr = 5'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("raw_stall_c%0d", c), 32'(bus.iss_stall), 32'd1);
            chk($sformatf("raw_accept_c%0d", c), 32'(bus.iss_accept), 32'd0);
            step();
        end
        bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hAA;
        #1;
        chk("raw_release_stall", 32'(bus.iss_stall), 32'd0);
        chk("raw_release_accept", 32'(bus.iss_accept), 32'd1);
        chk("raw_release_rs2", bus.rs2_data, 32'hAA);
        step();
        idle();
        #1;
        chk("raw_pend_cnt0", 32'(bus.pend_cnt), 32'd0);

        // WAW and simultaneous set/clear on x9
        bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd9;
        #1;
        chk("waw_first_accept", 32'(bus.iss_accept), 32'd1);
        step();
        #1;
        chk("waw_stall", 32'(bus.iss_stall), 32'd1);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h99;
        #1;
        chk("waw_same_edge_accept", 32'(bus.iss_accept), 32'd1);
        step();
        idle();
        bus.rs1_addr = 5'd9;
        #1;
        chk("waw_pend_cnt", 32'(bus.pend_cnt), 32'd1);
        chk("waw_data_x9", bus.rs1_data, 32'h99);
        bus.iss_valid = 1'b1;
        #1;
        chk("waw_x9_still_pending", 32'(bus.iss_stall), 32'd1);
        idle();
        bus.wb_en = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h100;
        step();
        idle();
        #1;
        chk("waw_retire_cnt", 32'(bus.pend_cnt), 32'd0);

        // Counter fill x1..x31, then retire in reverse order
        for (int i = 1; i < NREGS; i++) begin
            bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'(i);
            step();
        end
        idle();
        #1;
        chk("fill_pend_cnt", 32'(bus.pend_cnt), 32'(NREGS - 1));
        for (int i = NREGS - 1; i >= 1; i--) begin
            bus.wb_en = 1'b1; bus.wb_rd = 5'(i); bus.wb_data = 32'(i * 16 + 1);
            step();
            #1;
            chk($sformatf("drain_cnt_x%0d", i), 32'(bus.pend_cnt), 32'(i - 1));
        end
        bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h11;
        step();
        idle();
        #1;
        chk("no_underflow", 32'(bus.pend_cnt), 32'd0);

        // Async reset mid-operation with x1..x4 pending and nonzero data
        for (int i = 1; i <= 4; i++) begin
            bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'(i);
            step();
        end
        idle();
        bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd4;
        #1;
        chk("ar_pre_cnt", 32'(bus.pend_cnt), 32'd4);
        chk("ar_pre_x3", bus.rs1_data, 32'h31);
        rst_n = 1'b0;
        #1;
        chk("ar_cnt_now", 32'(bus.pend_cnt), 32'd0);
        chk("ar_x3_now", bus.rs1_data, 32'h0);
        chk("ar_x4_now", bus.rs2_data, 32'h0);
        bus.iss_valid = 1'b1;
        bus.wb_en = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h55;
        #1;
        chk("ar_stall_in_reset", 32'(bus.iss_stall), 32'd0);
        chk("ar_bypass_in_reset", bus.rs2_data, 32'h55);
        idle();
        #1;
        rst_n = 1'b1;
        step();
        bus.iss_valid = 1'b1; bus.rs1_addr = 5'd3;
        #1;
        chk("ar_dep_accept", 32'(bus.iss_accept), 32'd1);
        chk("ar_post_x3", bus.rs1_data, 32'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
